// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared widths, the command struct and small helpers for the
// RAM port arbiter. NUM_REQ/ADDR_WIDTH/DATA_WIDTH/BE_WIDTH size every port of
// the arbiter and its interface; REQ_ID_WIDTH sizes requester indices.
package ram_arb_pkg;

  localparam int NUM_REQ      = 2;
  localparam int ADDR_WIDTH   = 8;
  localparam int DATA_WIDTH   = 128;
  localparam int BE_WIDTH     = DATA_WIDTH / 8;
  localparam int REQ_ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // One RAM command; we == 0 means read, any set bit means byte write.
  typedef struct packed {
    logic [BE_WIDTH-1:0]   we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [REQ_ID_WIDTH-1:0] id);
    id_to_onehot = NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundles the requester-side handshake, the shared read
// response and the RAM macro pins of the arbiter.
//   slave  : arbiter view (takes requests and ram_dout, drives the rest)
//   master : requester/RAM-model view (the opposite directions)
// Handshake: a command transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a requester holds its command stable until then.
// rsp_valid is a one-cycle strobe; rsp_rdata is meaningful only with it.
interface ram_port_arbiter_if;
  import ram_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*BE_WIDTH-1:0]   req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          ram_ce;
  logic [BE_WIDTH-1:0]           ram_we;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0]         ram_din;
  logic [DATA_WIDTH-1:0]         ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_ce, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_ce, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant with a registered priority
// pointer. The search starts at the pointer and wraps; after an accepted
// grant the pointer moves to the requester just past the winner.
//   clk, rst     : clock, synchronous active-high reset (pointer -> 0)
//   req_i        : request vector
//   accept_i     : current grant was taken this cycle
//   grant_o      : one-hot grant (zero when no request)
//   grant_idx_o  : index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 accept_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [IDX_WIDTH-1:0] grant_idx_o
);

  // One spare bit so pointer + offset never overflows before the wrap.
  localparam int CW = IDX_WIDTH + 1;

  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]        cand;
  logic                 found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && req_i[cand[IDX_WIDTH-1:0]]) begin
        found       = 1'b1;
        grant_idx_o = cand[IDX_WIDTH-1:0];
        grant_o     = NUM_REQ'(1) << cand[IDX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = (grant_idx_o == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx_o + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port, byte-enabled, synchronous-read RAM
// among NUM_REQ requesters. Round-robin grant each cycle, winning command
// registered onto the RAM pins, read data strobed back to its issuer two
// cycles after acceptance.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester handshake, shared response and RAM pins (slave view)
module ram_port_arbiter
  import ram_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ram_port_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0]      grant;
  logic [REQ_ID_WIDTH-1:0] grant_idx;
  logic                    xfer;
  cmd_t                    win_cmd;

  cmd_t                    cmd_q;
  logic                    ce_q;
  logic                    rd_pending_q;
  logic [REQ_ID_WIDTH-1:0] rd_id_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rdata_hold_q;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_ID_WIDTH)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (bus.req_valid),
    .accept_i    (xfer),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // The RAM never stalls, so any grant outside reset is a transfer.
  assign bus.req_ready = rst ? '0 : grant;
  assign xfer          = !rst && (|grant);

  always_comb begin
    win_cmd.we    = bus.req_we[grant_idx*BE_WIDTH +: BE_WIDTH];
    win_cmd.addr  = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    win_cmd.wdata = bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Command stage: the RAM sees the accepted command one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q        <= '0;
      ce_q         <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_id_q      <= '0;
    end else begin
      ce_q         <= xfer;
      rd_pending_q <= xfer && (win_cmd.we == '0);
      if (xfer) begin
        cmd_q   <= win_cmd;
        rd_id_q <= grant_idx;
      end else begin
        // Idle cycle: drop the byte enables, leave addr/din as they were.
        cmd_q.we <= '0;
      end
    end
  end

  // Response stage: the strobe is timed to the cycle ram_dout carries the
  // read word; the hold register keeps rsp_rdata steady between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rdata_hold_q <= '0;
    end else begin
      rsp_valid_q <= rd_pending_q ? id_to_onehot(rd_id_q) : '0;
      if (|rsp_valid_q) rdata_hold_q <= bus.ram_dout;
    end
  end

  assign bus.ram_ce    = ce_q;
  assign bus.ram_we    = cmd_q.we;
  assign bus.ram_addr  = cmd_q.addr;
  assign bus.ram_din   = cmd_q.wdata;
  assign bus.rsp_valid = rsp_valid_q;
  // ram_dout is already a register inside the RAM macro.
  assign bus.rsp_rdata = (|rsp_valid_q) ? bus.ram_dout : rdata_hold_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed cycles with hand-computed grants
// and read data, behavioural RAM model, expected-response queue.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int EW = NUM_REQ + DATA_WIDTH;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [EW-1:0]      exp_q[$];
  logic [NUM_REQ-1:0] prev_ready;

  logic [DATA_WIDTH-1:0] mem [256];

  ram_port_arbiter_if bus();

  ram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (act=running req=finished)");
    $fatal(1, "timeout");
  end

  // ---------------- RAM model ----------------
  // Reset reloads a known pattern: word i holds byte i in every lane,
  // except word 0x40 which holds 0x11 in every lane.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] b;
        b = i[7:0];
        mem[i] <= (i == 'h40) ? {16{8'h11}} : {16{b}};
      end
    end else if (bus.ram_ce) begin
      if (bus.ram_we == '0) begin
        bus.ram_dout <= mem[bus.ram_addr];
      end else begin
        for (int b = 0; b < BE_WIDTH; b++)
          if (bus.ram_we[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_din[b*8 +: 8];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] act,
                       input logic [DATA_WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [BE_WIDTH-1:0] we,
                         input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] wdata);
    bus.req_we[i*BE_WIDTH +: BE_WIDTH]       = we;
    bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
  endtask

  // Checks this cycle's grant, RAM enable from last cycle's grant, and the
  // response expected from two cycles ago; queues this cycle's expectation.
  task automatic step(input string tag, input logic [NUM_REQ-1:0] exp_ready,
                      input logic exp_rd, input logic [DATA_WIDTH-1:0] exp_data);
    logic [EW-1:0] e;
    #1;
    check({tag, "_ready"}, DATA_WIDTH'(bus.req_ready), DATA_WIDTH'(exp_ready));
    check({tag, "_ce"}, DATA_WIDTH'(bus.ram_ce), DATA_WIDTH'(|prev_ready));
    prev_ready = exp_ready;
    exp_q.push_back({(exp_rd ? exp_ready : NUM_REQ'(0)), exp_data});
    if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
      check({tag, "_rsp_valid"}, DATA_WIDTH'(bus.rsp_valid), DATA_WIDTH'(e[EW-1:DATA_WIDTH]));
      if (e[EW-1:DATA_WIDTH] != '0)
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, e[DATA_WIDTH-1:0]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_WIDTH-1:0] d20, d30, d31, a5, pw;
    logic [7:0] ab;
    d20 = {16{8'h20}};
    d30 = {16{8'h30}};
    d31 = {16{8'h31}};
    a5  = {16{8'hA5}};
    pw  = {{15{8'h11}}, 8'h77};
    n_tests = 0;
    n_fail  = 0;
    prev_ready = '0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // 1: reset with both requesters valid, then requester 0 wins first
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.req_valid = '1;
      set_req(0, '0, 8'h20, '0);
      set_req(1, '0, 8'h21, '0);
      step("rst_hold", '0, 1'b0, '0);
      check("rst_ram_we", DATA_WIDTH'(bus.ram_we), '0);
      check("rst_ram_addr", DATA_WIDTH'(bus.ram_addr), '0);
      check("rst_ram_din", bus.ram_din, '0);
      check("rst_rsp_rdata", bus.rsp_rdata, '0);
    end
    tick(); rst = 1'b0;
    step("rr_first", 2'b01, 1'b1, d20);
    tick(); bus.req_valid = '0;
    step("rr_d0", '0, 1'b0, '0);
    check("rr_ram_addr", DATA_WIDTH'(bus.ram_addr), DATA_WIDTH'(8'h20));
    tick(); step("rr_d1", '0, 1'b0, '0);

    // 2: full write by req0, read back by req1
    tick(); set_req(0, '1, 8'h10, a5); bus.req_valid = 2'b01;
    step("t2_wr", 2'b01, 1'b0, '0);
    tick(); set_req(1, '0, 8'h10, '0); bus.req_valid = 2'b10;
    step("t2_rd", 2'b10, 1'b1, a5);
    check("t2_ram_we", DATA_WIDTH'(bus.ram_we), DATA_WIDTH'(16'hFFFF));
    check("t2_ram_addr", DATA_WIDTH'(bus.ram_addr), DATA_WIDTH'(8'h10));
    check("t2_ram_din", bus.ram_din, a5);
    tick(); bus.req_valid = '0;
    step("t2_d0", '0, 1'b0, '0);
    check("t2_rd_ram_we", DATA_WIDTH'(bus.ram_we), '0);
    tick(); step("t2_d1", '0, 1'b0, '0);
    tick(); step("t2_d2", '0, 1'b0, '0);

    // 3: both reading continuously, grants alternate
    set_req(0, '0, 8'h30, '0);
    set_req(1, '0, 8'h31, '0);
    for (int k = 0; k < 8; k++) begin
      tick(); bus.req_valid = 2'b11;
      step($sformatf("t3_%0d", k), (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
           (k % 2 == 0) ? d30 : d31);
    end
    tick(); bus.req_valid = '0; step("t3_d0", '0, 1'b0, '0);
    tick(); step("t3_d1", '0, 1'b0, '0);

    // 4: partial write then immediate read of the same word
    tick(); set_req(0, 16'h0001, 8'h40, {16{8'h77}}); bus.req_valid = 2'b01;
    step("t4_wr", 2'b01, 1'b0, '0);
    tick(); set_req(0, '0, 8'h40, '0);
    step("t4_rd", 2'b01, 1'b1, pw);
    tick(); bus.req_valid = '0; step("t4_d0", '0, 1'b0, '0);
    tick(); step("t4_d1", '0, 1'b0, '0);

    // 5: reset the cycle after a read is accepted
    tick(); set_req(1, '0, 8'h31, '0); bus.req_valid = 2'b10;
    step("t5_rd", 2'b10, 1'b1, d31);
    tick(); bus.req_valid = '0; rst = 1'b1;
    #1;
    check("t5_ce_inflight", DATA_WIDTH'(bus.ram_ce), DATA_WIDTH'(1'b1));
    exp_q.delete();
    prev_ready = '0;
    tick(); rst = 1'b0;
    step("t5_post", '0, 1'b0, '0);
    check("t5_no_rsp", DATA_WIDTH'(bus.rsp_valid), '0);
    tick(); set_req(0, '0, 8'h30, '0); bus.req_valid = 2'b11;
    step("t5_ptr0", 2'b01, 1'b1, d30);
    check("t5_no_rsp2", DATA_WIDTH'(bus.rsp_valid), '0);
    tick(); step("t5_next", 2'b10, 1'b1, d31);

    // 6: single requester streaming reads, no bubbles
    for (int k = 0; k < 5; k++) begin
      tick();
      ab = 8'(8'h50 + k);
      set_req(1, '0, ab, '0);
      bus.req_valid = 2'b10;
      step($sformatf("t6_%0d", k), 2'b10, 1'b1, {16{ab}});
    end
    tick(); bus.req_valid = '0; step("t6_d0", '0, 1'b0, '0);
    tick(); step("t6_d1", '0, 1'b0, '0);
    tick(); step("t6_d2", '0, 1'b0, '0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
